// File: rtl/mram_serial_bridge.sv
// Serial-to-parallel bridge for an asynchronous MRAM: shifts in address/data LSB first,
// runs a fixed-length strobe access, and serialises read data. Optional burst: MRAM_BURST_EN.
module mram_serial_bridge #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 20,
    parameter int WAIT_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              read_write_sel,
    input  logic [1:0]        byte_sel,
    input  logic              addr_in,
    input  logic              data_in,
    input  logic [DATA_W-1:0] parallel_data_in,
`ifdef MRAM_BURST_EN
    input  logic [7:0]        burst_len,
`endif
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              ser_data_out,
    output logic              chip_en,
    output logic              write_en,
    output logic              out_en,
    output logic              lower_byte_en,
    output logic              upper_byte_en,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX0 = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_MAX  = (CNT_MAX0 > WAIT_CYC) ? CNT_MAX0 : WAIT_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_ADDR,
        SHIFT_DATA,
        ACCESS,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              rw_q;
    logic [1:0]        bsel_q;
    logic [DATA_W-1:0] rd_shift;
    // {chip_en, write_en, out_en, lower_byte_en, upper_byte_en}
    logic [4:0]        strb;
    logic              last_word;

    assign {chip_en, write_en, out_en, lower_byte_en, upper_byte_en} = strb;

    // With no byte lane selected the access still takes its time slot but touches nothing.
    function automatic logic [4:0] access_strobes(input logic rw, input logic [1:0] bs);
        logic en;
        en = |bs;
        return {~en, ~(en & rw), ~(en & ~rw), ~bs[0], ~bs[1]};
    endfunction

`ifdef MRAM_BURST_EN
    logic [7:0] words_left;
    logic       word_end;

    assign word_end  = (state == ACCESS && cnt == WAIT_LAST && rw_q) ||
                       (state == SHIFT_OUT && cnt == DATA_LAST);
    assign last_word = (words_left <= 8'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            words_left <= 8'd0;
        end else if (state == IDLE && start) begin
            words_left <= (burst_len == 8'd0) ? 8'd1 : burst_len;
        end else if (word_end && !last_word) begin
            words_left <= words_left - 8'd1;
        end
    end
`else
    assign last_word = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rw_q         <= 1'b0;
            bsel_q       <= 2'b00;
            rd_shift     <= '0;
            strb         <= 5'b11111;
            addr_out     <= '0;
            data_out     <= '0;
            ser_data_out <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SHIFT_ADDR;
                        cnt    <= '0;
                        rw_q   <= read_write_sel;
                        bsel_q <= byte_sel;
                        busy   <= 1'b1;
                    end
                end

                SHIFT_ADDR: begin
                    addr_out <= {addr_in, addr_out[ADDR_W-1:1]};
                    if (cnt == ADDR_LAST) begin
                        cnt <= '0;
                        if (rw_q) begin
                            state <= SHIFT_DATA;
                        end else begin
                            state <= ACCESS;
                            strb  <= access_strobes(rw_q, bsel_q);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                SHIFT_DATA: begin
                    data_out <= {data_in, data_out[DATA_W-1:1]};
                    if (cnt == DATA_LAST) begin
                        cnt   <= '0;
                        state <= ACCESS;
                        strb  <= access_strobes(rw_q, bsel_q);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ACCESS: begin
                    if (cnt == WAIT_LAST) begin
                        cnt  <= '0;
                        strb <= 5'b11111;
                        if (!rw_q) begin
                            // Bit 0 goes straight to the pin; the rest wait in rd_shift.
                            state        <= SHIFT_OUT;
                            ser_data_out <= parallel_data_in[0];
                            rd_shift     <= parallel_data_in >> 1;
                        end else if (last_word) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= SHIFT_DATA;
                            addr_out <= addr_out + ADDR_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                SHIFT_OUT: begin
                    if (cnt == DATA_LAST) begin
                        cnt          <= '0;
                        ser_data_out <= 1'b0;
                        if (last_word) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ACCESS;
                            addr_out <= addr_out + ADDR_W'(1);
                            strb     <= access_strobes(rw_q, bsel_q);
                        end
                    end else begin
                        cnt          <= cnt + CNT_W'(1);
                        ser_data_out <= rd_shift[0];
                        rd_shift     <= rd_shift >> 1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    strb  <= 5'b11111;
                end
            endcase
        end
    end

endmodule
